hex_trace_sequencer: RTL and testbench
======================================

Name: hex_trace_sequencer

Overview:
Sequences the hex-nibble-to-binary converter to assemble one trace record (command code plus up to 8-nibble address) from a nibble stream delivered MSB-first. Accepts nibbles under a valid/ready handshake, instantiates the converter for every address nibble, and presents a complete {command, address} record to the cache-controller front end under a second valid/ready handshake. Rejects malformed records (bad command, overlong address) and resynchronises on the record delimiter.

Parameters:
ADDR_NIBBLES, 8, maximum address nibbles per record; address width = 4*ADDR_NIBBLES.
CNT_W, 4, width of nibble counter and out_ndigits; must hold ADDR_NIBBLES.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_nibble/in_last valid
in_ready  output  1  sequencer accepts nibble this cycle
in_nibble  input  4  hex digit value; first nibble of a record is the command
in_last  input  1  marks final nibble of the record
out_valid  output  1  record available
out_ready  input  1  downstream accepts record
out_cmd  output  4  command code
out_addr  output  4*ADDR_NIBBLES  assembled address, right-justified, zero-extended
out_ndigits  output  CNT_W  number of address nibbles received (0..ADDR_NIBBLES)
err  output  1  one-cycle pulse: malformed record discarded

Behaviour:
- Nibble accepted when in_valid && in_ready. Record accepted when out_valid && out_ready.
- States: IDLE (expect command), ADDR (accumulate address), HOLD (present record), DRAIN (discard to delimiter).
- Reset: state IDLE; out_valid=0, out_cmd=0, out_addr=0, out_ndigits=0, err=0; in_ready=1 once reset deasserts. Reset mid-record discards partial record; no err.
- in_ready = 1 in IDLE, ADDR, DRAIN; 0 in HOLD.
- Valid commands: 0,1,2,3,4,8,9. Any other value is invalid.
- IDLE, nibble accepted:
  - valid cmd, in_last=0 -> latch cmd, clear addr and count, go ADDR.
  - valid cmd, in_last=1 -> latch cmd, addr=0, ndigits=0, go HOLD (address-less record, e.g. 8/9).
  - invalid cmd -> err pulse next cycle; go DRAIN if in_last=0, else stay IDLE.
- ADDR, nibble accepted: addr <= {addr[4*ADDR_NIBBLES-5:0], converter_out}; count+1.
  - in_last=1 and count+1 <= ADDR_NIBBLES -> go HOLD.
  - count already = ADDR_NIBBLES (overflow nibble) -> err pulse, record dropped; go IDLE if in_last, else DRAIN.
- DRAIN: accept and discard nibbles; in_last -> IDLE. No further err pulses.
- HOLD: out_valid=1; out_cmd/out_addr/out_ndigits stable until accepted; on accept go IDLE with out_valid=0 next cycle.
- Latency: out_valid rises the cycle after the in_last nibble is accepted. Max throughput: one record per (nibbles+1) cycles; no bubble between IDLE acceptance and prior HOLD exit beyond the HOLD cycle itself.
- Fewer than ADDR_NIBBLES digits: leading zeros implied (right-justified).
- err is registered, exactly one cycle wide, per rejected record.
- in_nibble/in_last ignored whenever in_valid=0 or in_ready=0.

Test Plan:
- Stream 3,1,2,3,4,A,B,C,D (last on D), out_ready=1 -> out_valid one cycle after D; cmd=3, addr=0x1234ABCD, ndigits=8, err=0.
- Stream 0,F,F (last on F) -> cmd=0, addr=0x000000FF, ndigits=2.
- Single nibble 9 with in_last -> cmd=9, addr=0, ndigits=0; then 8 with in_last -> cmd=8, addr=0.
- Command 5, then 1,2 (last on 2) -> one err pulse, no out_valid; following record 2,A (last) outputs cmd=2, addr=0xA.
- Nine address nibbles after cmd 1 (last on ninth) -> err pulse after ninth, no out_valid; state IDLE.
- Hold out_ready=0 for 5 cycles with record pending -> outputs stable, in_ready=0; then out_ready=1 -> accept, in_ready=1 next cycle. Assert rst mid-ADDR -> all outputs 0, next record assembles cleanly.

Source files
------------

// File: rtl/hex_trace_sequencer.sv
`timescale 1ns/1ps
// hex_nibble_conv
//   Converts one hex digit, delivered as a 4-bit nibble value, into its 4-bit
//   binary weight for insertion into the address accumulator.
//   nibble : hex digit value 0..F
//   value  : binary weight of that digit
module hex_nibble_conv (
  input  logic [3:0] nibble,
  output logic [3:0] value
);
  always_comb begin
    value = nibble;
  end
endmodule

// hex_trace_sequencer
//   Assembles one trace record (command nibble followed by up to ADDR_NIBBLES
//   address nibbles, MSB first) from a valid/ready nibble stream. It presents
//   the finished {cmd, addr, ndigits} record under a second valid/ready
//   handshake. Malformed records (unknown command, too many address nibbles)
//   are dropped with a one-cycle err pulse, and the rest of the record is
//   discarded up to its in_last delimiter.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_nibble/in_last : nibble stream input
//   out_valid/out_ready                 : record handshake
//   out_cmd/out_addr/out_ndigits        : record contents (addr right-justified)
//   err           : one-cycle pulse per discarded record
module hex_trace_sequencer #(
  parameter int ADDR_NIBBLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_nibble,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_cmd,
  output logic [4*ADDR_NIBBLES-1:0] out_addr,
  output logic [CNT_W-1:0]          out_ndigits,
  output logic                      err
);
  localparam int AW = 4 * ADDR_NIBBLES;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(ADDR_NIBBLES);

  typedef enum logic [1:0] {IDLE, ADDR, HOLD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [3:0]       digit;
  logic             in_acc;

  hex_nibble_conv u_conv (
    .nibble (in_nibble),
    .value  (digit)
  );

  function automatic logic cmd_ok(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    in_acc    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_acc) begin
          if (cmd_ok(in_nibble)) begin
            cmd_d   = in_nibble;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = in_last ? HOLD : ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = in_last ? IDLE : DRAIN;
          end
        end
      end
      ADDR: begin
        if (in_acc) begin
          if (cnt_q == MAX_CNT) begin
            err_d   = 1'b1;
            state_d = in_last ? IDLE : DRAIN;
          end else begin
            // Concatenate then truncate so the shift stays legal for any depth.
            addr_d = AW'({addr_q, digit});
            cnt_d  = cnt_q + CNT_W'(1);
            if (in_last) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (in_acc && in_last) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_cmd     = cmd_q;
    out_addr    = addr_q;
    out_ndigits = cnt_q;
    err         = err_q;
  end
endmodule

// File: tb/tb_hex_trace_sequencer.sv
`timescale 1ns/1ps
module tb_hex_trace_sequencer;
  localparam int ADDR_NIBBLES = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nibble;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_cmd;
  logic [31:0] out_addr;
  logic [3:0]  out_ndigits;
  logic        err;

  int total = 0;
  int bad = 0;
  int rec[$];

  hex_trace_sequencer #(.ADDR_NIBBLES(ADDR_NIBBLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_nibble(in_nibble), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .out_addr(out_addr), .out_ndigits(out_ndigits), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a record is good when its first nibble is a known command and
  // at most ADDR_NIBBLES nibbles follow; the address is the base-16 number
  // spelled by the following nibbles.
  task automatic run_record(input int hold_cycles, input bit gaps);
    bit          good;
    int          nd;
    int          cmd;
    longint      addr;
    int          errs;
    cmd  = rec[0];
    nd   = rec.size() - 1;
    good = (cmd inside {0, 1, 2, 3, 4, 8, 9}) && (nd <= ADDR_NIBBLES);
    addr = 0;
    for (int i = 1; i < rec.size(); i++) addr = addr * 16 + rec[i];
    errs = 0;
    for (int i = 0; i < rec.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        errs += int'(err);
        in_valid  = 1'b0;
        in_nibble = 4'($urandom);
        in_last   = 1'($urandom);
      end
      @(negedge clk);
      errs += int'(err);
      chk("in_ready_stream", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_nibble = 4'(rec[i]);
      in_last   = (i == rec.size() - 1);
    end
    @(negedge clk);
    errs += int'(err);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_after_last", 64'(out_valid), 64'(good));
    if (good) begin
      chk("out_cmd", 64'(out_cmd), 64'(cmd));
      chk("out_addr", 64'(out_addr), 64'(addr));
      chk("out_ndigits", 64'(out_ndigits), 64'(nd));
      chk("err_count_good", 64'(errs), 64'd0);
      for (int h = 0; h < hold_cycles; h++) begin
        in_valid  = 1'($urandom);
        in_nibble = 4'($urandom);
        in_last   = 1'($urandom);
        @(negedge clk);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_cmd", 64'(out_cmd), 64'(cmd));
        chk("hold_addr", 64'(out_addr), 64'(addr));
        chk("hold_ndigits", 64'(out_ndigits), 64'(nd));
        chk("hold_err", 64'(err), 64'd0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("released_valid", 64'(out_valid), 64'd0);
      chk("released_in_ready", 64'(in_ready), 64'd1);
      chk("released_err", 64'(err), 64'd0);
    end else begin
      chk("err_count_bad", 64'(errs), 64'd1);
      @(negedge clk);
      chk("bad_no_valid", 64'(out_valid), 64'd0);
      chk("bad_err_cleared", 64'(err), 64'd0);
      chk("bad_idle_ready", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_nibble = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cmd", 64'(out_cmd), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_ndigits", 64'(out_ndigits), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    rec = '{3, 1, 2, 3, 4, 'hA, 'hB, 'hC, 'hD}; run_record(0, 0);
    rec = '{0, 'hF, 'hF};                        run_record(1, 0);
    rec = '{9};                                  run_record(0, 0);
    rec = '{8};                                  run_record(0, 0);
    rec = '{5, 1, 2};                            run_record(0, 0);
    rec = '{2, 'hA};                             run_record(0, 0);
    rec = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 9};       run_record(0, 0);
    rec = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 3, 3}; run_record(0, 0);
    rec = '{7};                                  run_record(0, 0);
    rec = '{4, 'hE};                             run_record(5, 0);

    // Reset in the middle of an address: partial record vanishes, no err.
    @(negedge clk); in_valid = 1'b1; in_nibble = 4'h1; in_last = 1'b0;
    @(negedge clk); in_nibble = 4'h5;
    @(negedge clk); in_nibble = 4'h6;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_cmd", 64'(out_cmd), 64'd0);
    chk("midrst_addr", 64'(out_addr), 64'd0);
    chk("midrst_ndigits", 64'(out_ndigits), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(negedge clk); rst = 1'b0;
    rec = '{4, 7, 7}; run_record(0, 0);

    for (int r = 0; r < 60; r++) begin
      int n;
      int vcmds[7];
      vcmds = '{0, 1, 2, 3, 4, 8, 9};
      n = $urandom_range(0, 10);
      rec.delete();
      if ($urandom_range(0, 3) == 0) rec.push_back(int'($urandom_range(0, 15)));
      else rec.push_back(vcmds[$urandom_range(0, 6)]);
      for (int k = 0; k < n; k++) rec.push_back(int'($urandom_range(0, 15)));
      run_record($urandom_range(0, 3), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
